// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//
// Multi-cycle instruction fetch unit for the NPC core, sitting directly in
// front of the decoder. It owns the architectural PC. For each instruction it
// performs these steps in order:
//   1. Issue one AXI4-Lite-style read to instruction memory.
//   2. Hand the fetched word and its PC to the decoder through a valid/ready
//      pair.
//   3. Wait for write-back to return the next PC before fetching again.
//
// Ports:
//   clk            core clock, all state updates on posedge
//   rst            asynchronous reset, active-low
//   pc_next_valid  write-back offers the next PC
//   pc_next        next PC from write-back
//   pc_next_ready  fetch unit accepts the next PC
//   araddr         read address to instruction memory
//   arvalid        read address valid
//   arready        memory accepts the address
//   rdata          read data
//   rresp          read response, 2'b00 = OKAY, anything else is an error
//   rvalid         read data valid
//   rready         fetch unit accepts read data
//   inst_valid     instruction available to the decoder
//   inst_ready     decoder accepts the instruction
//   inst           fetched instruction
//   inst_pc        PC of inst
//   inst_err       fetch fault for this instruction, qualified by inst_valid
//   fetch_cnt      number of instructions delivered to the decoder
// ---------------------------------------------------------------------------
module ifu_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h80000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_next_valid,
    input  logic [ADDR_W-1:0] pc_next,
    output logic              pc_next_ready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err,
    output logic [63:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        S_AR      = 2'd0,
        S_R       = 2'd1,
        S_OUT     = 2'd2,
        S_WAIT_PC = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              misaligned;

    // A PC that is not word aligned never reaches the bus. It is turned
    // straight into a faulting instruction.
    assign misaligned = (pc[1:0] != 2'b00);

    // The PC is held for the whole fetch, so the bus address and the
    // reported instruction PC can both come straight from it.
    assign araddr  = pc;
    assign inst_pc = pc;

    // State register. Reset returns to the address phase, and any bus
    // response still in flight is then ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_AR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Each state advances only when its own handshake
    // completes, so at most one bus read is ever outstanding.
    always_comb begin
        state_nxt = state;
        case (state)
            S_AR: begin
                if (misaligned) begin
                    state_nxt = S_OUT;
                end else if (arready) begin
                    state_nxt = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    state_nxt = S_WAIT_PC;
                end
            end
            S_WAIT_PC: begin
                if (pc_next_valid) begin
                    state_nxt = S_AR;
                end
            end
            default: state_nxt = S_AR;
        endcase
    end

    // Handshake outputs are decoded from the state. They are also masked by
    // reset, so every valid/ready drops the moment reset is asserted, even
    // in the middle of a transaction.
    always_comb begin
        arvalid       = 1'b0;
        rready        = 1'b0;
        inst_valid    = 1'b0;
        pc_next_ready = 1'b0;
        if (rst) begin
            arvalid       = (state == S_AR) && !misaligned;
            rready        = (state == S_R);
            inst_valid    = (state == S_OUT);
            pc_next_ready = (state == S_WAIT_PC);
        end
    end

    // Datapath registers. The instruction and its fault flag are captured on
    // the read data beat, or synthesised for a misaligned PC. The PC changes
    // only when write-back hands over the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            inst      <= '0;
            inst_err  <= 1'b0;
            fetch_cnt <= 64'd0;
        end else begin
            case (state)
                S_AR: begin
                    if (misaligned) begin
                        inst     <= '0;
                        inst_err <= 1'b1;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        inst     <= rdata;
                        inst_err <= (rresp != 2'b00);
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        fetch_cnt <= fetch_cnt + 64'd1;
                    end
                end
                S_WAIT_PC: begin
                    if (pc_next_valid) begin
                        pc <= pc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch
//
// Self-checking bench for ifu_fetch. The bench plays instruction memory, the
// decoder and write-back, with configurable random stalls on every handshake.
// When a read address is accepted, the expected instruction is pushed to a
// scoreboard. It is popped and compared when the decoder handshake completes.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h80000000;

    logic        clk;
    logic        rst;
    logic        pc_next_valid;
    logic [31:0] pc_next;
    logic        pc_next_ready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic [63:0] fetch_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  resp;
        int          max_stall;
        logic [31:0] next_pc;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } sb_t;

    vec_t  vecs [8];
    sb_t   sb [$];
    int    tests;
    int    fails;
    longint exp_cnt;

    ifu_fetch #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_next_valid (pc_next_valid),
        .pc_next       (pc_next),
        .pc_next_ready (pc_next_ready),
        .araddr        (araddr),
        .arvalid       (arvalid),
        .arready       (arready),
        .rdata         (rdata),
        .rresp         (rresp),
        .rvalid        (rvalid),
        .rready        (rready),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_err      (inst_err),
        .fetch_cnt     (fetch_cnt)
    );

    // Free-running core clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a wedged design still ends the run.
    initial begin
        #3000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "[TB] time limit reached");
    end

    // Instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RESET_PC) begin
            return 32'h00000413;
        end
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Compares one observed value with its expected value.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advances to the next falling edge and checks that at most one
    // handshake output is high.
    task automatic tick();
        @(negedge clk);
        checkOutput("onehot", 64'($countones({arvalid, rready, inst_valid, pc_next_ready}) <= 1), 64'd1);
    endtask

    function automatic logic cur_sig(input int sel);
        case (sel)
            0:       return arvalid;
            1:       return rready;
            2:       return inst_valid;
            default: return pc_next_ready;
        endcase
    endfunction

    // Waits, with a bound, for the selected handshake output to rise.
    task automatic wait_sig(input int sel, output int waited);
        waited = 0;
        while (!cur_sig(sel) && waited < 20) begin
            tick();
            waited++;
        end
        if (!cur_sig(sel)) begin
            checkOutput($sformatf("timeout_sig%0d", sel), 64'd0, 64'd1);
        end
    endtask

    // Runs one complete instruction: address, data, decoder and next-PC
    // phases, each with up to max_stall wait cycles.
    task automatic applyStimulus(input logic [31:0] pc, input logic [1:0] resp, input int max_stall,
                                 input logic [31:0] next_pc, input logic [31:0] exp_inst, input logic exp_err);
        int          w;
        int          k;
        sb_t         e;
        logic [31:0] addr;
        e.pc   = pc;
        e.inst = exp_inst;
        e.err  = exp_err;
        if (pc[1:0] == 2'b00) begin
            wait_sig(0, w);
            checkOutput("ar_latency", 64'(w), 64'd0);
            k = $urandom_range(max_stall, 0);
            repeat (k) begin
                arready = 1'b0;
                checkOutput("ar_stall_valid", 64'(arvalid), 64'd1);
                checkOutput("ar_stall_addr", 64'(araddr), 64'(pc));
                tick();
            end
            checkOutput("araddr", 64'(araddr), 64'(pc));
            addr = araddr;
            sb.push_back(e);
            arready = 1'b1;
            tick();
            arready = 1'b0;
            wait_sig(1, w);
            checkOutput("r_latency", 64'(w), 64'd0);
            k = $urandom_range(max_stall, 0);
            repeat (k) begin
                rvalid = 1'b0;
                rdata  = 32'hDEADBEEF;
                rresp  = 2'b11;
                checkOutput("r_stall_ready", 64'(rready), 64'd1);
                checkOutput("r_stall_noar", 64'(arvalid), 64'd0);
                tick();
            end
            rvalid = 1'b1;
            rdata  = mem_word(addr);
            rresp  = resp;
            tick();
            rvalid = 1'b0;
            rdata  = 32'hDEADBEEF;
            rresp  = 2'b00;
        end else begin
            checkOutput("mis_arvalid", 64'(arvalid), 64'd0);
            checkOutput("mis_rready", 64'(rready), 64'd0);
            sb.push_back(e);
            tick();
            checkOutput("mis_arvalid2", 64'(arvalid), 64'd0);
        end

        wait_sig(2, w);
        checkOutput("out_latency", 64'(w), 64'd0);
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb[0];
        k = $urandom_range(max_stall, 0);
        repeat (k) begin
            inst_ready = 1'b0;
            checkOutput("out_stall_valid", 64'(inst_valid), 64'd1);
            checkOutput("out_stall_inst", 64'(inst), 64'(e.inst));
            checkOutput("out_stall_pc", 64'(inst_pc), 64'(e.pc));
            tick();
        end
        checkOutput("inst", 64'(inst), 64'(e.inst));
        checkOutput("inst_pc", 64'(inst_pc), 64'(e.pc));
        checkOutput("inst_err", 64'(inst_err), 64'(e.err));
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        void'(sb.pop_front());
        exp_cnt++;
        checkOutput("fetch_cnt", fetch_cnt, 64'(exp_cnt));

        wait_sig(3, w);
        checkOutput("wait_latency", 64'(w), 64'd0);
        k = $urandom_range(max_stall, 0);
        repeat (k) begin
            pc_next_valid = 1'b0;
            pc_next       = 32'h0BAD0000;
            checkOutput("wait_stall_ready", 64'(pc_next_ready), 64'd1);
            tick();
        end
        pc_next_valid = 1'b1;
        pc_next       = next_pc;
        tick();
        pc_next_valid = 1'b0;
        pc_next       = 32'h0BAD0000;
    endtask

    initial begin
        int          w;
        logic [31:0] p;
        tests   = 0;
        fails   = 0;
        exp_cnt = 0;

        // Fetch sequence: a reset fetch, a branch redirect, an error
        // response, a misaligned PC and a stalled fetch.
        vecs[0] = '{RESET_PC,     2'b00, 0, 32'h80000004, 32'h00000413,            1'b0};
        vecs[1] = '{32'h80000004, 2'b00, 0, 32'h80000008, mem_word(32'h80000004), 1'b0};
        vecs[2] = '{32'h80000008, 2'b00, 0, 32'h80000040, mem_word(32'h80000008), 1'b0};
        vecs[3] = '{32'h80000040, 2'b00, 2, 32'h80000010, mem_word(32'h80000040), 1'b0};
        vecs[4] = '{32'h80000010, 2'b10, 1, 32'h80000014, mem_word(32'h80000010), 1'b1};
        vecs[5] = '{32'h80000014, 2'b00, 0, 32'h80000102, mem_word(32'h80000014), 1'b0};
        vecs[6] = '{32'h80000102, 2'b00, 0, 32'h80000200, 32'h00000000,            1'b1};
        vecs[7] = '{32'h80000200, 2'b00, 3, 32'h80000204, mem_word(32'h80000200), 1'b0};

        rst           = 1'b0;
        pc_next_valid = 1'b0;
        pc_next       = 32'h0BAD0000;
        arready       = 1'b0;
        rdata         = 32'hDEADBEEF;
        rresp         = 2'b00;
        rvalid        = 1'b0;
        inst_ready    = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_arvalid", 64'(arvalid), 64'd0);
        checkOutput("rst_inst_valid", 64'(inst_valid), 64'd0);
        checkOutput("rst_inst", 64'(inst), 64'd0);
        checkOutput("rst_inst_err", 64'(inst_err), 64'd0);
        checkOutput("rst_fetch_cnt", fetch_cnt, 64'd0);
        checkOutput("rst_araddr", 64'(araddr), 64'(RESET_PC));

        rst = 1'b1;
        #1;
        checkOutput("rel_arvalid", 64'(arvalid), 64'd1);
        checkOutput("rel_araddr", 64'(araddr), 64'(RESET_PC));

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].pc, vecs[i].resp, vecs[i].max_stall,
                          vecs[i].next_pc, vecs[i].exp_inst, vecs[i].exp_err);
        end
        checkOutput("table_cnt", fetch_cnt, 64'd8);

        // Reset asserted while waiting for read data that is already pending.
        wait_sig(0, w);
        checkOutput("mr_ar_latency", 64'(w), 64'd0);
        checkOutput("mr_araddr", 64'(araddr), 64'h80000204);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checkOutput("mr_in_r", 64'(rready), 64'd1);
        rvalid = 1'b1;
        rdata  = 32'h12345678;
        rresp  = 2'b00;
        #2 rst = 1'b0;
        #1;
        checkOutput("mr_arvalid", 64'(arvalid), 64'd0);
        checkOutput("mr_rready", 64'(rready), 64'd0);
        checkOutput("mr_inst_valid", 64'(inst_valid), 64'd0);
        checkOutput("mr_pc_next_ready", 64'(pc_next_ready), 64'd0);
        checkOutput("mr_fetch_cnt", fetch_cnt, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("mr_rel_arvalid", 64'(arvalid), 64'd1);
        checkOutput("mr_rel_araddr", 64'(araddr), 64'(RESET_PC));
        checkOutput("mr_rel_rready", 64'(rready), 64'd0);
        tick();
        checkOutput("mr_ignore_arvalid", 64'(arvalid), 64'd1);
        checkOutput("mr_ignore_rready", 64'(rready), 64'd0);
        checkOutput("mr_ignore_inst_valid", 64'(inst_valid), 64'd0);
        rvalid  = 1'b0;
        rdata   = 32'hDEADBEEF;
        sb.delete();
        exp_cnt = 0;

        // 100 sequential fetches from the reset PC with random stalls.
        p = RESET_PC;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(p, 2'b00, 5, p + 32'd4, mem_word(p), 1'b0);
            p = p + 32'd4;
        end
        checkOutput("stress_cnt", fetch_cnt, 64'd100);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
